// File: rtl/aclk_setter_pkg.sv
// Shared types and BCD limits for the aclock time/alarm setter front-end.
package aclk_setter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EDIT_HOUR = 2'd1,
    EDIT_MIN  = 2'd2,
    LOAD      = 2'd3
  } state_t;

  typedef enum logic {
    TGT_TIME  = 1'b0,
    TGT_ALARM = 1'b1
  } target_t;

  localparam logic [3:0] HR_MAX_T      = 4'd2;
  localparam logic [3:0] HR_MAX_U_AT_2 = 4'd3;
  localparam logic [3:0] MIN_MAX_T     = 4'd5;
  localparam logic [3:0] DIG_MAX       = 4'd9;

endpackage

// File: rtl/aclk_bcd_inc.sv
// Combinational two-digit BCD increment with wrap: 23->00 for hours, 59->00 for minutes.
module aclk_bcd_inc
  import aclk_setter_pkg::*;
(
  input  logic       is_min,
  input  logic [3:0] tens,
  input  logic [3:0] units,
  output logic [3:0] tens_next,
  output logic [3:0] units_next
);

  logic at_max;

  always_comb begin
    at_max     = is_min ? ((tens == MIN_MAX_T) && (units == DIG_MAX))
                        : ((tens == HR_MAX_T) && (units == HR_MAX_U_AT_2));
    tens_next  = tens;
    units_next = units + 4'd1;
    if (at_max) begin
      tens_next  = 4'd0;
      units_next = 4'd0;
    end else if (units == DIG_MAX) begin
      tens_next  = tens + 4'd1;
      units_next = 4'd0;
    end
  end

endmodule

// File: rtl/aclk_time_setter.sv
// Button-driven editor producing H/M BCD digits and LD_time/LD_alarm strobes for aclock.
// Optional hold-to-repeat increment is enabled by defining ALARM_AUTOREPEAT_EN.
module aclk_time_setter
  import aclk_setter_pkg::*;
#(
  parameter int LOAD_CYC    = 2,
  parameter int TIMEOUT_CYC = 1000
`ifdef ALARM_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       sel_alarm,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       editing,
  output logic       field
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int LW = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

  state_t        state_reg, state_next;
  target_t       target_reg, target_next;
  logic          mode_prev_reg, inc_prev_reg;
  logic [1:0]    h1_reg, h1_next;
  logic [3:0]    h0_reg, h0_next, m1_reg, m1_next, m0_reg, m0_next;
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [LW-1:0] ld_cnt_reg, ld_cnt_next;

  logic       mode_evt, inc_evt, in_edit, is_min, bump, rep_fire;
  logic [3:0] inc_tens, inc_units, inc_tens_next, inc_units_next;

  assign mode_evt = btn_mode & ~mode_prev_reg;
  assign inc_evt  = btn_inc & ~inc_prev_reg;
  assign in_edit  = (state_reg == EDIT_HOUR) || (state_reg == EDIT_MIN);
  assign is_min   = (state_reg == EDIT_MIN);
  // Mode takes priority: an increment coinciding with a mode event is dropped.
  assign bump     = in_edit & ~mode_evt & (inc_evt | rep_fire);

  assign inc_tens  = is_min ? m1_reg : {2'b00, h1_reg};
  assign inc_units = is_min ? m0_reg : h0_reg;

  aclk_bcd_inc u_bcd_inc (
    .is_min     (is_min),
    .tens       (inc_tens),
    .units      (inc_units),
    .tens_next  (inc_tens_next),
    .units_next (inc_units_next)
  );

`ifdef ALARM_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX) + 1;

  logic [RW-1:0] rep_cnt_reg, rep_cnt_next;

  // Down-counter of hold cycles left before the next repeat; zero means inactive.
  always_comb begin
    rep_cnt_next = '0;
    rep_fire     = 1'b0;
    if (in_edit && !mode_evt && btn_inc) begin
      if (inc_evt) begin
        rep_cnt_next = RW'(REPEAT_DELAY - 1);
      end else if (rep_cnt_reg == RW'(1)) begin
        rep_fire     = 1'b1;
        rep_cnt_next = RW'(REPEAT_PERIOD);
      end else if (rep_cnt_reg != '0) begin
        rep_cnt_next = rep_cnt_reg - RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rep_cnt_reg <= '0;
    else        rep_cnt_reg <= rep_cnt_next;
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    target_next  = target_reg;
    h1_next      = h1_reg;
    h0_next      = h0_reg;
    m1_next      = m1_reg;
    m0_next      = m0_reg;
    tmo_cnt_next = tmo_cnt_reg + TW'(1);
    ld_cnt_next  = '0;
    case (state_reg)
      IDLE: begin
        tmo_cnt_next = '0;
        if (mode_evt) begin
          state_next  = EDIT_HOUR;
          target_next = sel_alarm ? TGT_ALARM : TGT_TIME;
        end
      end
      EDIT_HOUR, EDIT_MIN: begin
        if (mode_evt) begin
          state_next   = (state_reg == EDIT_HOUR) ? EDIT_MIN : LOAD;
          tmo_cnt_next = '0;
        end else if (bump) begin
          tmo_cnt_next = '0;
          if (is_min) begin
            m1_next = inc_tens_next;
            m0_next = inc_units_next;
          end else begin
            h1_next = inc_tens_next[1:0];
            h0_next = inc_units_next;
          end
        end else if (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
          state_next = IDLE;
        end
      end
      LOAD: begin
        tmo_cnt_next = '0;
        if (ld_cnt_reg == LW'(LOAD_CYC - 1)) state_next  = IDLE;
        else                                 ld_cnt_next = ld_cnt_reg + LW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      target_reg    <= TGT_TIME;
      mode_prev_reg <= 1'b0;
      inc_prev_reg  <= 1'b0;
      h1_reg        <= '0;
      h0_reg        <= '0;
      m1_reg        <= '0;
      m0_reg        <= '0;
      tmo_cnt_reg   <= '0;
      ld_cnt_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      target_reg    <= target_next;
      mode_prev_reg <= btn_mode;
      inc_prev_reg  <= btn_inc;
      h1_reg        <= h1_next;
      h0_reg        <= h0_next;
      m1_reg        <= m1_next;
      m0_reg        <= m0_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      ld_cnt_reg    <= ld_cnt_next;
    end
  end

  assign H_in1    = h1_reg;
  assign H_in0    = h0_reg;
  assign M_in1    = m1_reg;
  assign M_in0    = m0_reg;
  assign LD_time  = (state_reg == LOAD) && (target_reg == TGT_TIME);
  assign LD_alarm = (state_reg == LOAD) && (target_reg == TGT_ALARM);
  assign editing  = in_edit;
  assign field    = is_min;

endmodule

// File: tb/tb_aclk_time_setter.sv
// Scoreboard bench for aclk_time_setter: commits and aborts are queued by the stimulus and checked by a monitor.
module tb_aclk_time_setter;

  logic       clk = 1'b0;
  logic       reset, btn_mode, btn_inc, sel_alarm;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, editing, field;

  aclk_time_setter dut (
    .clk       (clk),
    .reset     (reset),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .sel_alarm (sel_alarm),
    .H_in1     (H_in1),
    .H_in0     (H_in0),
    .M_in1     (M_in1),
    .M_in0     (M_in0),
    .LD_time   (LD_time),
    .LD_alarm  (LD_alarm),
    .editing   (editing),
    .field     (field)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit commit;
    bit alarm;
    int digits;
    int len;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic int cur_digits();
    return int'({H_in1, H_in0, M_in1, M_in0});
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; tick();
    btn_mode = 1'b0; tick();
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      btn_inc = 1'b1; tick();
      btn_inc = 1'b0; tick();
    end
  endtask

  task automatic expect_ev(input bit c, input bit a, input int d, input int len);
    exp_t e;
    e.commit = c; e.alarm = a; e.digits = d; e.len = len;
    exp_q.push_back(e);
  endtask

  // Monitor: an exit from editing is either a commit (LD pulse) or an abort.
  initial begin
    logic ed_prev;
    exp_t e;
    bit   g_commit, g_alarm;
    int   g_digits, g_len;
    ed_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (LD_time || LD_alarm) check("ld_exclusive", int'(LD_time & LD_alarm), 0);
      if (ed_prev && !editing) begin
        g_commit = LD_time | LD_alarm;
        g_alarm  = LD_alarm;
        g_digits = cur_digits();
        g_len    = 0;
        if (g_commit) begin
          g_len = 1;
          for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (LD_time || LD_alarm) g_len++;
            else break;
          end
        end
        if (exp_q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", int'(g_commit), int'(e.commit));
          check("event_digits", g_digits, e.digits);
          if (e.commit) begin
            check("ld_target", int'(g_alarm), int'(e.alarm));
            check("ld_len", g_len, e.len);
          end
          $display("event commit=%0d alarm=%0d digits=%h len=%0d", g_commit, g_alarm, g_digits[13:0], g_len);
        end
      end
      ed_prev = editing;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; sel_alarm = 1'b0;
    repeat (3) tick();
    reset = 1'b1; tick();
    check("rst_digits", cur_digits(), 'h0000);
    check("rst_ld", int'({LD_time, LD_alarm}), 0);
    check("rst_editing", int'(editing), 0);
    check("rst_field", int'(field), 0);

    // Basic time set to 13:45
    press_mode();
    check("enter_editing", int'(editing), 1);
    check("enter_field", int'(field), 0);
    press_inc(13);
    press_mode();
    check("min_field", int'(field), 1);
    press_inc(45);
    check("set_1345", cur_digits(), 'h1345);
    expect_ev(1'b1, 1'b0, 'h1345, 2);
    press_mode();
    repeat (6) tick();
    check("idle_after_load", int'(editing), 0);

    // Wrap boundaries
    press_mode();
    press_inc(10);
    check("hour_23", cur_digits(), 'h2345);
    press_inc(1);
    check("hour_wrap", cur_digits(), 'h0045);
    press_mode();
    press_inc(14);
    check("min_59", cur_digits(), 'h0059);
    press_inc(1);
    check("min_wrap", cur_digits(), 'h0000);
    press_inc(9);
    check("min_09", cur_digits(), 'h0009);
    press_inc(1);
    check("min_carry", cur_digits(), 'h0010);
    expect_ev(1'b1, 1'b0, 'h0010, 2);
    press_mode();
    repeat (6) tick();

    // Alarm target latched at entry, sel_alarm changes afterwards ignored
    sel_alarm = 1'b1;
    press_mode();
    sel_alarm = 1'b0;
    press_inc(1);
    press_mode();
    press_inc(1);
    expect_ev(1'b1, 1'b1, 'h0111, 2);
    press_mode();
    repeat (6) tick();

    // Timeout abort
    press_mode();
    repeat (990) tick();
    check("pre_timeout_editing", int'(editing), 1);
    expect_ev(1'b0, 1'b0, 'h0111, 0);
    repeat (20) tick();
    check("post_timeout_editing", int'(editing), 0);

    // Simultaneous mode+inc, then reset during LOAD
    press_mode();
    btn_mode = 1'b1; btn_inc = 1'b1; tick();
    btn_mode = 1'b0; btn_inc = 1'b0; tick();
    check("simul_field", int'(field), 1);
    check("simul_digits", cur_digits(), 'h0111);
    expect_ev(1'b0, 1'b0, 'h0000, 0);
    btn_mode = 1'b1; tick();
    check("load_started", int'(LD_time), 1);
    reset = 1'b0;
    #1;
    check("rst_load_ld", int'({LD_time, LD_alarm}), 0);
    check("rst_load_digits", cur_digits(), 'h0000);
    btn_mode = 1'b0; tick();
    reset = 1'b1; tick();

    // Held increment in minute field
    press_mode();
    press_mode();
    btn_inc = 1'b1;
    repeat (80) tick();
    btn_inc = 1'b0; tick();
`ifdef ALARM_AUTOREPEAT_EN
    check("hold_inc", cur_digits(), 'h0005);
    expect_ev(1'b1, 1'b0, 'h0005, 2);
`else
    check("hold_inc", cur_digits(), 'h0001);
    expect_ev(1'b1, 1'b0, 'h0001, 2);
`endif
    press_mode();
    repeat (10) tick();

    check("pending_events", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aclk_time_setter.md
Name: aclk_time_setter

Overview:
- Button-driven front-end that generates the time/alarm configuration inputs of the aclock alarm-clock core: H_in1, H_in0, M_in1, M_in0, LD_time and LD_alarm.
- The operator steps through hour and minute fields in BCD and then commits them with a load pulse.
- Sits between the (already synchronised, debounced) panel buttons and aclock; transmitter end of the aclk_tconfig interface.

Parameters:
LOAD_CYC, 2, cycles LD_time/LD_alarm stay asserted on commit (>=1)
TIMEOUT_CYC, 1000, idle cycles in an edit state before abort without load (>=2)
REPEAT_DELAY, 50, hold cycles before first auto-repeat (AUTOREPEAT_EN only)
REPEAT_PERIOD, 10, cycles between auto-repeat increments (AUTOREPEAT_EN only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
btn_mode  in  1  level; rising edge advances FSM
btn_inc  in  1  level; rising edge increments active field
sel_alarm  in  1  sampled on IDLE->EDIT_HOUR; 1=alarm target, 0=time target
H_in1  out  2  hour tens BCD (0..2)
H_in0  out  4  hour units BCD (0..9)
M_in1  out  4  minute tens BCD (0..5)
M_in0  out  4  minute units BCD (0..9)
LD_time  out  1  load-time strobe to aclock
LD_alarm  out  1  load-alarm strobe to aclock
editing  out  1  high in EDIT_HOUR/EDIT_MIN
field  out  1  0=hour, 1=minute (valid while editing)

Behaviour:
- Reset (async assert, sync release): state IDLE; all digits 0 (00:00); LD_time=LD_alarm=0; editing=0; field=0; target=time; counters 0.
- Edge detect: registered previous value per button; event = level & ~prev; one event max per press; prev registers reset to 0 (button held through reset release yields one event).
- States: IDLE, EDIT_HOUR, EDIT_MIN, LOAD.
- IDLE: mode event -> EDIT_HOUR, latch target=sel_alarm. inc events ignored.
- EDIT_HOUR: inc event -> hour+1; mode event -> EDIT_MIN.
- EDIT_MIN: inc event -> minute+1; mode event -> LOAD.
- LOAD: assert LD_time (target=time) or LD_alarm (target=alarm) for exactly LOAD_CYC cycles starting the cycle after the mode event; then IDLE. Button events ignored in LOAD.
- Never both LD outputs high. Digits change only on inc events in edit states; stable through LOAD and IDLE (values persist across edit sessions).
- Hour increment BCD: 23 -> 00; H_in0==9 -> H_in1+1, H_in0=0; else H_in0+1. Minute: 59 -> 00; M_in0==9 -> M_in1+1, M_in0=0; else M_in0+1. Illegal BCD unreachable.
- Digit outputs registered; update one cycle after event edge.
- Simultaneous mode+inc events: mode wins, inc discarded.
- Timeout: counter cleared on entering an edit state and on any button event; reaching TIMEOUT_CYC-1 in edit -> IDLE, no LD pulse, digits keep edited values.
- Reset mid-LOAD: LD deasserts immediately (async).

Optional Feature:
- Macro ALARM_AUTOREPEAT_EN.
- Defined: in edit state, btn_inc held continuously for REPEAT_DELAY cycles after its edge generates an extra increment, then one every REPEAT_PERIOD cycles while held; repeat increments also clear timeout; release or mode event stops repeat.
- Undefined: only rising edges increment; REPEAT_* unused; no repeat counter logic synthesised.

Decomposition:
- Package aclk_setter_pkg: state enum (IDLE, EDIT_HOUR, EDIT_MIN, LOAD), target enum (TGT_TIME, TGT_ALARM), BCD limit constants (HR_MAX_T=2, HR_MAX_U_AT_2=3, MIN_MAX_T=5, DIG_MAX=9).
- Sub-module aclk_bcd_inc: combinational, mode input (hour/minute), increments a two-digit BCD field with wrap; instantiated once, muxed by field.

Test Plan:
- Reset, mode, sel_alarm=0, 13 inc, mode, 45 inc, mode -> H=1,3 M=4,5; LD_time high 2 cycles; LD_alarm 0; IDLE.
- Hour preset 23, inc -> 00; minute preset 59, inc -> 00; minute 09 inc -> 10.
- sel_alarm=1 at entry, toggled to 0 mid-edit -> commit pulses LD_alarm only, 2 cycles.
- Enter edit, no buttons for 1000 cycles -> editing=0, no LD pulse, digits retained.
- mode and inc same cycle in EDIT_HOUR -> state EDIT_MIN, hour unchanged; reset asserted in LOAD cycle 1 -> LD=0 and 00:00 immediately.
- ALARM_AUTOREPEAT_EN: hold inc 80 cycles in EDIT_MIN from 00 -> 1+1+3 = 05.
